// File: rtl/hdmi_vram_fetch_pkg.sv
// hdmi_pkg: shared definitions for the HDMI VRAM fetch engine.
//   - fetch_state_e : fetch FSM states
//   - SRC_W_720P_DIV4 / SRC_H_720P_DIV4 : default source size (1280x720 / 4)
//   - fetch_lat()   : output latency derived from the VRAM read latency
package hdmi_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_VBLANK,
    S_LINE,
    S_HBLANK
  } fetch_state_e;

  localparam int unsigned SRC_W_720P_DIV4 = 320;
  localparam int unsigned SRC_H_720P_DIV4 = 180;

  // One extra stage beyond the RAM latency for the registered pixel output.
  function automatic int unsigned fetch_lat(input int unsigned rd_lat);
    return rd_lat + 1;
  endfunction

endpackage

// File: rtl/hdmi_vram_fetch_if.sv
// hdmi_vram_fetch_if: VRAM read port between the fetch engine and the RAM.
//   ram_re    : read enable (fetch -> RAM)
//   ram_addr  : read address (fetch -> RAM)
//   ram_rdata : read data, valid RD_LAT cycles after ram_re (RAM -> fetch)
// Modports: master = fetch engine, slave = RAM.
interface hdmi_vram_fetch_if #(
  parameter int unsigned PIX_W  = 8,
  parameter int unsigned ADDR_W = 16
);
  logic              ram_re;
  logic [ADDR_W-1:0] ram_addr;
  logic [PIX_W-1:0]  ram_rdata;

  modport master (output ram_re, output ram_addr, input  ram_rdata);
  modport slave  (input  ram_re, input  ram_addr, output ram_rdata);
endinterface

// File: rtl/hdmi_delay_line.sv
// hdmi_delay_line: N-stage, W-bit shift register with asynchronous reset.
//   clk, rst : clock, async active-high reset (clears all stages)
//   d_i      : input word
//   q_o      : d_i delayed by N cycles
module hdmi_delay_line #(
  parameter int unsigned N = 1,
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] stage_q [N];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < N; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= d_i;
      for (int unsigned i = 1; i < N; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign q_o = stage_q[N-1];

endmodule

// File: rtl/hdmi_vram_fetch.sv
// hdmi_vram_fetch: pixel-clock fetch engine from a downscaled VRAM framebuffer
// to the HDMI encoder path. Each source pixel is replicated 2^SCALE_LOG2 times
// per axis; timing signals are delayed LAT = RD_LAT+1 cycles to match data.
// Ports:
//   clk, rst            : pixel clock, async active-high reset
//   vs_i, hs_i, de_i    : input video timing
//   fb_base, stride     : frame base / line stride, latched on vs_i rise
//   tp_en               : test-pattern select (HDMI_FETCH_TESTPAT_EN only)
//   vram                : VRAM read port (hdmi_vram_fetch_if.master)
//   vs_o, hs_o, de_o    : timing delayed LAT cycles
//   pix_o               : pixel aligned with de_o (0 when de_o = 0)
//   frame_err           : sticky, de_i rose before any vsync
// Optional feature macro: HDMI_FETCH_TESTPAT_EN.
module hdmi_vram_fetch
  import hdmi_pkg::*;
#(
  parameter int unsigned       PIX_W      = 8,
  parameter int unsigned       ADDR_W     = 16,
  parameter int unsigned       SCALE_LOG2 = 2,
  parameter int unsigned       SRC_W      = SRC_W_720P_DIV4,
  parameter int unsigned       SRC_H      = SRC_H_720P_DIV4,
  parameter int unsigned       RD_LAT     = 1,
  parameter logic [PIX_W-1:0]  BORDER     = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              vs_i,
  input  logic              hs_i,
  input  logic              de_i,
  input  logic [ADDR_W-1:0] fb_base,
  input  logic [ADDR_W-1:0] stride,
`ifdef HDMI_FETCH_TESTPAT_EN
  input  logic              tp_en,
`endif
  hdmi_vram_fetch_if.master vram,
  output logic              vs_o,
  output logic              hs_o,
  output logic              de_o,
  output logic [PIX_W-1:0]  pix_o,
  output logic              frame_err
);

  localparam int unsigned LAT   = fetch_lat(RD_LAT);
  localparam int unsigned SUB_W = (SCALE_LOG2 == 0) ? 1 : SCALE_LOG2;
  localparam int unsigned XS_W  = $clog2(SRC_W + 1);
  localparam int unsigned YS_W  = $clog2(SRC_H + 1);
  localparam logic [SUB_W-1:0] SUB_MAX = SUB_W'((1 << SCALE_LOG2) - 1);
  localparam logic [XS_W-1:0]  X_END   = XS_W'(SRC_W);
  localparam logic [YS_W-1:0]  Y_END   = YS_W'(SRC_H);

  fetch_state_e      state_q, state_d;
  logic              vs_q, de_q;
  logic [ADDR_W-1:0] stride_q, stride_d;
  logic [ADDR_W-1:0] line_base_q, line_base_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [SUB_W-1:0]  x_sub_q, x_sub_d, y_sub_q, y_sub_d;
  logic [XS_W-1:0]   x_src_q, x_src_d;
  logic [YS_W-1:0]   y_src_q, y_src_d;
  logic              frame_err_q, frame_err_d;

  logic              vs_rise, de_rise;
  logic              slot, in_src;
  logic [ADDR_W-1:0] cur_addr;
  logic [SUB_W-1:0]  cur_x_sub;
  logic [XS_W-1:0]   cur_x_src;

  assign vs_rise = vs_i & ~vs_q;
  assign de_rise = de_i & ~de_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      vs_q        <= 1'b0;
      de_q        <= 1'b0;
      stride_q    <= '0;
      line_base_q <= '0;
      addr_q      <= '0;
      x_sub_q     <= '0;
      y_sub_q     <= '0;
      x_src_q     <= '0;
      y_src_q     <= '0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      vs_q        <= vs_i;
      de_q        <= de_i;
      stride_q    <= stride_d;
      line_base_q <= line_base_d;
      addr_q      <= addr_d;
      x_sub_q     <= x_sub_d;
      y_sub_q     <= y_sub_d;
      x_src_q     <= x_src_d;
      y_src_q     <= y_src_d;
      frame_err_q <= frame_err_d;
    end
  end

  // The de_i rising cycle is already the first active pixel, so the fetch for
  // it is issued in that same cycle from line_base / x = 0 (cur_* below)
  // rather than one cycle later from the S_LINE registers.
  always_comb begin
    state_d     = state_q;
    stride_d    = stride_q;
    line_base_d = line_base_q;
    addr_d      = addr_q;
    x_sub_d     = x_sub_q;
    y_sub_d     = y_sub_q;
    x_src_d     = x_src_q;
    y_src_d     = y_src_q;
    frame_err_d = frame_err_q;
    slot        = 1'b0;
    cur_addr    = addr_q;
    cur_x_sub   = x_sub_q;
    cur_x_src   = x_src_q;

    if (vs_rise) begin
      // Legal from every state, including mid-frame resync.
      state_d     = S_VBLANK;
      stride_d    = stride;
      line_base_d = fb_base;
      y_sub_d     = '0;
      y_src_d     = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (de_rise) frame_err_d = 1'b1;
        end
        S_VBLANK, S_HBLANK: begin
          if (de_rise) begin
            state_d   = S_LINE;
            slot      = 1'b1;
            cur_addr  = line_base_q;
            cur_x_sub = '0;
            cur_x_src = '0;
          end
        end
        S_LINE: begin
          if (de_i) begin
            slot = 1'b1;
          end else begin
            state_d = S_HBLANK;
            if (y_sub_q == SUB_MAX) begin
              y_sub_d     = '0;
              line_base_d = line_base_q + stride_q;
              if (y_src_q != Y_END) y_src_d = y_src_q + 1'b1;
            end else begin
              y_sub_d = y_sub_q + 1'b1;
            end
          end
        end
      endcase
    end

    if (slot) begin
      if (cur_x_sub == SUB_MAX) begin
        x_sub_d = '0;
        x_src_d = (cur_x_src == X_END) ? cur_x_src : cur_x_src + 1'b1;
        addr_d  = cur_addr + 1'b1;
      end else begin
        x_sub_d = cur_x_sub + 1'b1;
        x_src_d = cur_x_src;
        addr_d  = cur_addr;
      end
    end
  end

  assign in_src        = slot && (cur_x_src < X_END) && (y_src_q < Y_END);
  assign vram.ram_re   = in_src;
  assign vram.ram_addr = in_src ? cur_addr : '0;

  // Timing bits and in-source tag travel together; the output register below
  // supplies the last of the LAT stages.
  logic [3:0] tl_q;

  hdmi_delay_line #(.N(LAT - 1), .W(4)) u_timing_dl (
    .clk (clk),
    .rst (rst),
    .d_i ({vs_i, hs_i, de_i, in_src}),
    .q_o (tl_q)
  );

  logic [PIX_W-1:0] pix_d;

`ifdef HDMI_FETCH_TESTPAT_EN
  logic [PIX_W-1:0] tp_val;
  logic [PIX_W:0]   tp_dl;

  assign tp_val = PIX_W'(32'(cur_x_src) + 32'(y_src_q) * 32'(SRC_W));

  hdmi_delay_line #(.N(LAT - 1), .W(PIX_W + 1)) u_tp_dl (
    .clk (clk),
    .rst (rst),
    .d_i ({in_src & tp_en, tp_val}),
    .q_o (tp_dl)
  );
`endif

  always_comb begin
    pix_d = '0;
    if (tl_q[1]) pix_d = tl_q[0] ? vram.ram_rdata : BORDER;
`ifdef HDMI_FETCH_TESTPAT_EN
    if (tl_q[1] && tp_dl[PIX_W]) pix_d = tp_dl[PIX_W-1:0];
`endif
  end

  logic             vs_out_q, hs_out_q, de_out_q;
  logic [PIX_W-1:0] pix_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vs_out_q <= 1'b0;
      hs_out_q <= 1'b0;
      de_out_q <= 1'b0;
      pix_q    <= '0;
    end else begin
      vs_out_q <= tl_q[3];
      hs_out_q <= tl_q[2];
      de_out_q <= tl_q[1];
      pix_q    <= pix_d;
    end
  end

  assign vs_o      = vs_out_q;
  assign hs_o      = hs_out_q;
  assign de_o      = de_out_q;
  assign pix_o     = pix_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_hdmi_vram_fetch.sv
// Testbench for hdmi_vram_fetch: three instances with RD_LAT = 1, 2, 3 share
// one stimulus stream and one VRAM image; a frame-level reference model
// predicts every output cycle. Honours HDMI_FETCH_TESTPAT_EN when defined.
module tb_hdmi_vram_fetch;

  localparam int unsigned PW  = 8;
  localparam int unsigned AW  = 16;
  localparam int unsigned SL  = 2;
  localparam int unsigned SW  = 8;
  localparam int unsigned SH  = 4;
  localparam logic [7:0]  BRD = 8'hA5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        vs_i = 1'b0, hs_i = 1'b0, de_i = 1'b0;
  logic [15:0] fb_base = '0, stride = '0;
`ifdef HDMI_FETCH_TESTPAT_EN
  logic        tp_en = 1'b0;
`endif

  logic [7:0]  mem [65536];

  logic        vs_o [3];
  logic        hs_o [3];
  logic        de_o [3];
  logic [7:0]  pix_o [3];
  logic        ferr_o [3];
  logic        re_o [3];
  logic [15:0] addr_o [3];

  int unsigned tests = 0;
  int unsigned fails = 0;

  always #5 clk = ~clk;

  for (genvar k = 0; k < 3; k++) begin : g_lat
    hdmi_vram_fetch_if #(.PIX_W(PW), .ADDR_W(AW)) vif ();
    logic [7:0] rpipe [k+1];

    always @(posedge clk) begin
      rpipe[0] <= vif.ram_re ? mem[vif.ram_addr] : 8'hxx;
      for (int i = 1; i <= k; i++) rpipe[i] <= rpipe[i-1];
    end
    assign vif.ram_rdata = rpipe[k];
    assign re_o[k]       = vif.ram_re;
    assign addr_o[k]     = vif.ram_addr;

    hdmi_vram_fetch #(
      .PIX_W(PW), .ADDR_W(AW), .SCALE_LOG2(SL), .SRC_W(SW), .SRC_H(SH),
      .RD_LAT(k + 1), .BORDER(BRD)
    ) dut (
      .clk       (clk),
      .rst       (rst),
      .vs_i      (vs_i),
      .hs_i      (hs_i),
      .de_i      (de_i),
      .fb_base   (fb_base),
      .stride    (stride),
`ifdef HDMI_FETCH_TESTPAT_EN
      .tp_en     (tp_en),
`endif
      .vram      (vif),
      .vs_o      (vs_o[k]),
      .hs_o      (hs_o[k]),
      .de_o      (de_o[k]),
      .pix_o     (pix_o[k]),
      .frame_err (ferr_o[k])
    );
  end

  // Reference model state (frame-level view of the video stream).
  bit          in_frame, line_ok, vs_prev, de_prev, ferr_m, tp_m;
  logic [15:0] base_l, stride_l;
  int unsigned hcnt, vline, cyc;
  logic        h_vs [8];
  logic        h_hs [8];
  logic        h_de [8];
  logic [7:0]  h_pix [8];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    in_frame = 0; line_ok = 0; vs_prev = 0; de_prev = 0; ferr_m = 0;
    hcnt = 0; vline = 0;
    for (int i = 0; i < 8; i++) begin
      h_vs[i] = 0; h_hs[i] = 0; h_de[i] = 0; h_pix[i] = '0;
    end
  endtask

  // One pixel-clock cycle: drive inputs, check every output against the model.
  task automatic step(input logic v, input logic h, input logic d);
    bit          vsr, der, def, ferr_set, active, in_src;
    logic [15:0] a;
    logic [7:0]  p;
    int unsigned idx;
    @(posedge clk);
    #1;
    vs_i = v; hs_i = h; de_i = d;
    #1;
    vsr      = v && !vs_prev;
    der      = d && !de_prev;
    def      = !d && de_prev;
    ferr_set = !in_frame && der && !vsr;
    if (vsr) begin
      in_frame = 1; base_l = fb_base; stride_l = stride; vline = 0; line_ok = 0;
    end else begin
      if (der && in_frame) begin line_ok = 1; hcnt = 0; end
      if (def && line_ok) begin line_ok = 0; vline++; end
    end
    active = d && line_ok;
    in_src = active && (hcnt < (SW << SL)) && (vline < (SH << SL));
    a      = 16'(base_l + (vline >> SL) * stride_l + (hcnt >> SL));
    if (!d)          p = '0;
    else if (!in_src) p = BRD;
    else if (tp_m)   p = 8'((hcnt >> SL) + (vline >> SL) * SW);
    else             p = mem[a];

    for (int k = 0; k < 3; k++) begin
      idx = (cyc - (k + 2)) % 8;
      chk($sformatf("vs_o lat%0d", k + 2), vs_o[k], h_vs[idx]);
      chk($sformatf("hs_o lat%0d", k + 2), hs_o[k], h_hs[idx]);
      chk($sformatf("de_o lat%0d", k + 2), de_o[k], h_de[idx]);
      chk($sformatf("pix_o lat%0d", k + 2), pix_o[k], h_pix[idx]);
      chk($sformatf("frame_err lat%0d", k + 2), ferr_o[k], ferr_m);
      chk($sformatf("ram_re lat%0d", k + 2), re_o[k], in_src);
      if (in_src) chk($sformatf("ram_addr lat%0d", k + 2), addr_o[k], a);
    end

    h_vs[cyc % 8] = v; h_hs[cyc % 8] = h; h_de[cyc % 8] = d; h_pix[cyc % 8] = p;
    if (active) hcnt++;
    if (ferr_set) ferr_m = 1;
    vs_prev = v; de_prev = d;
    cyc++;
  endtask

  task automatic frame(input logic [15:0] base, input logic [15:0] st,
                       input int unsigned nlines, input bit midchange);
    int unsigned len, gap;
    fb_base = base; stride = st;
    step(0, 0, 0); step(1, 0, 0); step(1, 0, 0); step(0, 0, 0);
    if (midchange) begin fb_base = 16'($urandom); stride = 16'($urandom); end
    step(0, 0, 0);
    for (int unsigned l = 0; l < nlines; l++) begin
      len = $urandom_range(30, 36);
      gap = $urandom_range(1, 3);
      for (int unsigned i = 0; i < len; i++) step(0, 0, 1);
      step(0, 0, 0); step(0, 1, 0); step(0, 1, 0);
      for (int unsigned i = 0; i < gap; i++) step(0, 0, 0);
    end
  endtask

  initial begin
    cyc  = 16;
    tp_m = 0;
    model_reset();
    for (int i = 0; i < 65536; i++) mem[i] = i[7:0];

    #23 rst = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("reset vs_o", vs_o[k], 0);
      chk("reset hs_o", hs_o[k], 0);
      chk("reset de_o", de_o[k], 0);
      chk("reset pix_o", pix_o[k], 0);
      chk("reset ram_re", re_o[k], 0);
      chk("reset ram_addr", addr_o[k], 0);
      chk("reset frame_err", ferr_o[k], 0);
    end

    // Identity image, linear mapping with a 320-word stride.
    frame(16'h0000, 16'd320, 20, 0);

    // Random image: scroll base, mid-frame register changes, address wrap.
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    frame(16'h0140, 16'd320, 18, 1);
    frame(16'($urandom), 16'($urandom_range(1, 400)), 20, 1);
    frame(16'hFFF0, 16'h0010, 17, 0);
    frame(16'($urandom), 16'($urandom), 19, 1);

    // Reset in the middle of an active line.
    fb_base = 16'h1234; stride = 16'd40;
    step(0, 0, 0); step(1, 0, 0); step(0, 0, 0);
    for (int i = 0; i < 10; i++) step(0, 0, 1);
    #2 rst = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("midline rst vs_o", vs_o[k], 0);
      chk("midline rst hs_o", hs_o[k], 0);
      chk("midline rst de_o", de_o[k], 0);
      chk("midline rst pix_o", pix_o[k], 0);
      chk("midline rst ram_re", re_o[k], 0);
      chk("midline rst frame_err", ferr_o[k], 0);
    end
    de_i = 1'b0; vs_i = 1'b0; hs_i = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    model_reset();

    // Active line with no preceding vsync: border pixels, sticky error.
    for (int i = 0; i < 12; i++) step(0, 0, 1);
    for (int i = 0; i < 4; i++) step(0, 0, 0);
    for (int k = 0; k < 3; k++) chk("frame_err after orphan de", ferr_o[k], 1);

    frame(16'($urandom), 16'($urandom_range(1, 400)), 20, 1);

`ifdef HDMI_FETCH_TESTPAT_EN
    for (int i = 0; i < 65536; i++) mem[i] = 8'hFF;
    tp_en = 1'b1;
    tp_m  = 1;
    frame(16'($urandom), 16'($urandom_range(1, 400)), 20, 0);
    tp_en = 1'b0;
    tp_m  = 0;
`endif

    for (int i = 0; i < 6; i++) step(0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
